// File: rtl/tiny_alu_core.sv
// Single-command ALU (add/and/xor/mul) with a start/done handshake; 1-cycle latency, MUL_LATENCY for mul.
// No backpressure: the initiator holds start until done, then drops it for one cycle to release the block.
module tiny_alu_core #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        DONE     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [2:0]  r_op;
    logic [15:0] r_prod;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_result;

    logic [15:0] w_alu;
    logic        w_illegal;

    assign w_illegal = (r_op > OP_MUL);

    always_comb begin
        w_alu = 16'h0000;
        case (r_op)
            OP_ADD:  w_alu = {7'b0, {1'b0, r_a} + {1'b0, r_b}};
            OP_AND:  w_alu = {8'b0, r_a & r_b};
            OP_XOR:  w_alu = {8'b0, r_a ^ r_b};
            OP_MUL:  w_alu = r_prod;
            default: w_alu = 16'h0000;
        endcase
    end

    // Product is staged from the captured operands; MUL_LATENCY >= 2 guarantees it has settled before done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prod <= 16'h0000;
        end else begin
            r_prod <= 16'(r_a) * 16'(r_b);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_op     <= 3'b000;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (op != OP_NOP)) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= op;
                        r_cnt   <= (op == OP_MUL) ? MUL_CNT : 4'd1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // Dropping start mid-command aborts it silently.
                    if (!start) begin
                        r_cnt   <= 4'd0;
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt    <= 4'd0;
                        r_done   <= 1'b1;
                        r_err    <= w_illegal;
                        r_result <= w_alu;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign done   = r_done;
    assign err    = r_err;
    assign result = r_result;

endmodule

// File: tb/tb_tiny_alu_core.sv
// Directed-vector bench for tiny_alu_core; expected responses are queued at issue and checked by a monitor.
module tb_tiny_alu_core;

    localparam int ML = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic        err;
    logic [15:0] result;

    typedef struct packed {
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total  = 0;
    int   bad    = 0;
    int   n_done = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    tiny_alu_core #(.MUL_LATENCY(ML)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pops the oldest expected response.
    always @(negedge clk) begin
        if (reset_n && done) begin
            n_done++;
            check("done_single_cycle", {31'b0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %h err %b, expected no done", result, err);
            end else begin
                mon_e = q.pop_front();
                check("result", {16'b0, result}, {16'b0, mon_e.res});
                check("err", {31'b0, err}, {31'b0, mon_e.err});
            end
        end else if (reset_n && err) begin
            total++;
            bad++;
            $display("FAIL err_without_done: got err=1, expected 0");
        end
        prev_done = done;
    end

    // Issue one command, scramble the inputs after capture, measure latency, then release.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                           input logic [15:0] er, input logic ee, input int hold);
        int   cyc;
        int   d0;
        int   lat;
        exp_t e;
        lat   = (o == 3'b100) ? ML : 1;
        e.res = er;
        e.err = ee;
        q.push_back(e);
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        @(posedge clk);
        d0 = n_done;
        #1;
        A  = ~a;
        B  = b ^ 8'h5A;
        op = (o == 3'b100) ? 3'b001 : 3'b100;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!done && cyc < 20);
        check("latency", cyc, lat);
        repeat (hold) @(negedge clk);
        check("done_count", n_done - d0, 1);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int cyc;
        exp_t e;
        reset_n = 1'b0;
        start   = 1'b0;
        A = 8'h00; B = 8'h00; op = 3'b000;
        #1;
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_result", {16'b0, result}, 32'd0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;

        run_cmd(8'hFF, 8'h01, 3'b001, 16'h0100, 1'b0, 1);
        run_cmd(8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0, 1);
        run_cmd(8'h80, 8'h80, 3'b001, 16'h0100, 1'b0, 1);
        run_cmd(8'hFF, 8'h0F, 3'b010, 16'h000F, 1'b0, 1);
        run_cmd(8'hAA, 8'h55, 3'b011, 16'h00FF, 1'b0, 1);
        run_cmd(8'h10, 8'h10, 3'b100, 16'h0100, 1'b0, 1);
        run_cmd(8'h00, 8'hFF, 3'b100, 16'h0000, 1'b0, 1);
        run_cmd(8'h07, 8'h09, 3'b111, 16'h0000, 1'b1, 1);
        run_cmd(8'h0C, 8'h0D, 3'b100, 16'h009C, 1'b0, 1);

        // no_op pulse: nothing happens, result untouched
        d0 = n_done;
        @(negedge clk);
        A = 8'h12; B = 8'h34; op = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("noop_no_done", n_done - d0, 0);
        check("noop_result_hold", {16'b0, result}, 32'h0000_009C);
        run_cmd(8'h12, 8'h34, 3'b101, 16'h0000, 1'b1, 1);

        run_cmd(8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0, 5);
        run_cmd(8'hF0, 8'h3C, 3'b011, 16'h00CC, 1'b0, 1);

        // abort: start dropped one cycle after capture
        d0 = n_done;
        @(negedge clk);
        A = 8'hFF; B = 8'hFF; op = 3'b100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        check("abort_result_hold", {16'b0, result}, 32'h0000_00CC);
        run_cmd(8'h03, 8'h04, 3'b001, 16'h0007, 1'b0, 1);

        // asynchronous reset in the middle of a mul
        @(negedge clk);
        A = 8'h05; B = 8'h06; op = 3'b100; start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_done", {31'b0, done}, 32'd0);
        check("async_rst_result", {16'b0, result}, 32'd0);
        check("async_rst_err", {31'b0, err}, 32'd0);
        A = 8'h01; B = 8'h01; op = 3'b001;
        e.res = 16'h0002;
        e.err = 1'b0;
        q.push_back(e);
        d0 = n_done;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!done && cyc < 20);
        check("post_rst_latency", cyc, 2);
        @(negedge clk);
        check("post_rst_done_count", n_done - d0, 1);
        start = 1'b0;
        repeat (3) @(negedge clk);

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tiny_alu_core.md
TINY_ALU_CORE -- requirements
Module: tiny_alu_core

Interface
REQ-001 Parameter MUL_LATENCY, default 3, is the clk cycles from command capture to done for mul; legal range 2..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 A  input  8  operand A, unsigned.
REQ-005 B  input  8  operand B, unsigned.
REQ-006 op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101..111 illegal.
REQ-007 start  input  1  command request; the initiator holds it high until done is seen.
REQ-008 done  output  1  single-cycle completion strobe; result is valid in the same cycle.
REQ-009 result  output  16  operation result.
REQ-010 err  output  1  single-cycle strobe, coincident with done, for an illegal opcode.

Function
REQ-011 States SHALL be IDLE, BUSY, DONE and WAIT_REL, all registered.
REQ-012 In IDLE, on a clk edge with start=1 and op≠000, the block SHALL capture A, B and op into internal registers.
REQ-013 On that same edge it SHALL go to BUSY with a cycle counter loaded.
REQ-014 In IDLE with start=1 and op=000, the block SHALL stay in IDLE; it SHALL NOT assert done or change result.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-016 add/and/xor/illegal SHALL assert done on the first clk edge after capture (latency 1).
REQ-017 mul SHALL assert done MUL_LATENCY edges after capture.
REQ-018 add: result = {7'b0, 9-bit A+B}; the carry lands in bit 8.
REQ-019 and: result = {8'b0, A&B}.
REQ-020 xor: result = {8'b0, A^B}.
REQ-021 mul: result = 16-bit unsigned A*B; it may be computed in a multi-stage pipeline but SHALL appear only with done.
REQ-022 Illegal opcode: result SHALL be 16'h0000 and err=1 together with done.
REQ-023 done and err SHALL be high for exactly one clk cycle per accepted command.
REQ-024 result SHALL update only in the cycle done rises, and SHALL hold that value until the next done or reset.
REQ-025 Changes on A, B or op after capture SHALL NOT affect the in-flight command.
REQ-026 After done, the block SHALL enter WAIT_REL.
REQ-027 In WAIT_REL it SHALL accept no command until it samples start=0, then return to IDLE.
REQ-028 A start held high across done SHALL NOT start a second command.
REQ-029 Minimum command spacing SHALL be one cycle with start=0 between commands.
REQ-030 If start drops to 0 while in BUSY, the block SHALL abort: return to IDLE, no done, no err, result unchanged.
REQ-031 start=1 while in BUSY with different A/B/op SHALL be ignored; it counts as the same command.
REQ-032 Outputs done, err and result SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-033 While reset_n=0: done=0, err=0, result=16'h0000, state=IDLE, counter=0, captured operands=0.
REQ-034 Assertion of reset_n SHALL take effect immediately, without waiting for clk.
REQ-035 Reset during BUSY or WAIT_REL SHALL discard the command; no done SHALL follow reset release.
REQ-036 After reset_n deasserts, the first accepted command SHALL require a clk edge with start=1, with no start=0 cycle needed first.

Verification
REQ-037 add A=8'hFF, B=8'h01, start held high -> done one cycle after capture, result=16'h0100, err=0.
REQ-038 mul A=8'hFF, B=8'hFF, MUL_LATENCY=3 -> done exactly 3 edges after capture, result=16'hFE01.
REQ-039 Back-to-back commands:
- and 8'hF0/8'h3C then xor 8'hF0/8'h3C, one start-low cycle between them.
- Required: results 16'h0030 then 16'h00CC, each with a one-cycle done.
- Holding start high 5 cycles after the first done produces no second done.
REQ-040 op=000 with start pulsed for one cycle, then op=101 with A=8'h12, B=8'h34:
- no_op gives no done.
- op=101 gives done=1, err=1, result=16'h0000.
REQ-041 mul started, then start dropped after 1 cycle -> no done within 10 cycles, result keeps its prior value; a following add 3+4 returns 16'h0007.
REQ-042 reset_n asserted mid-mul, asynchronously between clk edges -> done/result go 0 immediately, no done after release, and the next add 1+1 returns 16'h0002.
